// File: rtl/pwm_servo_pkg.sv
// -----------------------------------------------------------------------------
// pwm_servo_pkg
// Shared definitions for the servo PWM bank: bus address map, the wide counter
// type and the helper functions used by the top and by each channel.
//   ADDR_PERIOD     bus address of the pending period register
//   ADDR_DUTY_BASE  bus address of channel 0's pending duty register
//   cnt_t           widest counter/duty/period type supported (CNT_W <= 32)
//   clamp_period    maps an active period below 2 up to 2
//   ramp_step       moves a duty value toward a target by a bounded step
// -----------------------------------------------------------------------------
package pwm_servo_pkg;

  localparam int CNT_W_MAX = 32;

  localparam logic [3:0] ADDR_PERIOD    = 4'd0;
  localparam logic [3:0] ADDR_DUTY_BASE = 4'd1;

  typedef logic [CNT_W_MAX-1:0] cnt_t;

  // A period of 0 or 1 would leave no room for a high and a low phase, and a
  // period of 0 would make the last-count compare underflow.
  function automatic cnt_t clamp_period(input cnt_t p);
    return (p < cnt_t'(2)) ? cnt_t'(2) : p;
  endfunction

  // Lands exactly on the target when it is within one step; never overshoots.
  function automatic cnt_t ramp_step(input cnt_t cur, input cnt_t tgt,
                                     input cnt_t step);
    cnt_t r;
    if (tgt > cur) begin
      r = ((tgt - cur) > step) ? (cur + step) : tgt;
    end else begin
      r = ((cur - tgt) > step) ? (cur - step) : tgt;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_servo_chan.sv
// -----------------------------------------------------------------------------
// pwm_servo_chan
// One PWM channel of the servo bank: pending/active duty registers and the
// registered compare against the shared period counter.
// Optional feature macro: SERVO_RAMP_EN (slew-limited duty at period end).
// Ports:
//   clk        clock, rising edge
//   res_n      asynchronous active-low reset
//   i_enable   bank enable; low loads the active duty directly, output low
//   i_we       write strobe for this channel's pending duty
//   i_data     duty value written
//   i_load     period boundary: active duty takes the (ramped) pending value
//   i_cnt      shared period counter
//   o_pwm      registered PWM output
// -----------------------------------------------------------------------------
module pwm_servo_chan
  import pwm_servo_pkg::*;
#(
  parameter int CNT_W = 32
`ifdef SERVO_RAMP_EN
  ,
  parameter int RAMP_STEP = 1000
`endif
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             i_enable,
  input  logic             i_we,
  input  logic [CNT_W-1:0] i_data,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_pwm
);

  logic [CNT_W-1:0] r_duty_pend;
  logic [CNT_W-1:0] r_duty_act;
  logic [CNT_W-1:0] w_duty_next;
  logic             r_pwm;

`ifdef SERVO_RAMP_EN
  assign w_duty_next = CNT_W'(ramp_step(cnt_t'(r_duty_act), cnt_t'(r_duty_pend),
                                        cnt_t'(RAMP_STEP)));
`else
  assign w_duty_next = r_duty_pend;
`endif

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_duty_pend <= '0;
    end else if (i_we) begin
      r_duty_pend <= i_data;
    end
  end

  // While idle the active duty tracks pending without ramping, so a restart
  // begins with the latest value.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_duty_act <= '0;
    end else if (!i_enable) begin
      r_duty_act <= r_duty_pend;
    end else if (i_load) begin
      r_duty_act <= w_duty_next;
    end
  end

  // Output stage: one clock behind the counter. duty >= period keeps the
  // output high for every count, duty = 0 keeps it low.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= i_enable && (i_cnt < r_duty_act);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_servo_bank.sv
// -----------------------------------------------------------------------------
// pwm_servo_bank
// NCH-channel servo PWM generator with one shared period counter. Period and
// duty writes go to pending registers and reach the active set only at a
// period boundary (or continuously while disabled), so pulses never glitch.
// Optional feature macro: SERVO_RAMP_EN (duty slews by RAMP_STEP per period).
// Ports:
//   clk      clock, rising edge
//   res_n    asynchronous active-low reset
//   enable   run the counter; low holds counter at 0 and outputs low
//   wr_en    write strobe, one cycle per write
//   wr_addr  0 = period, 1..NCH = duty of channel wr_addr-1, others ignored
//   wr_data  value written
//   per_end  high during the last count of every period
//   pwm      PWM outputs, bit i = channel i
// -----------------------------------------------------------------------------
module pwm_servo_bank
  import pwm_servo_pkg::*;
#(
  parameter int NCH        = 5,
  parameter int CNT_W      = 32,
  parameter int DEF_PERIOD = 2000000,
  parameter int RAMP_STEP  = 1000
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [CNT_W-1:0] wr_data,
  output logic             per_end,
  output logic [NCH-1:0]   pwm
);

  if (NCH < 1 || NCH > 15 || CNT_W < 2 || CNT_W > CNT_W_MAX || RAMP_STEP < 0)
  begin : g_bad_cfg
    $error("pwm_servo_bank: unsupported parameter set");
  end

  logic [CNT_W-1:0] r_per_pend;
  logic [CNT_W-1:0] r_per_act;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_per_last;
  logic             w_wrap;
  logic [NCH-1:0]   w_duty_we;

  assign w_per_last = CNT_W'(clamp_period(cnt_t'(r_per_act))) - CNT_W'(1);
  assign w_wrap     = enable && (r_cnt == w_per_last);
  assign per_end    = w_wrap;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_per_pend <= CNT_W'(DEF_PERIOD);
    end else if (wr_en && (wr_addr == ADDR_PERIOD)) begin
      r_per_pend <= wr_data;
    end
  end

  // A write landing on the wrap edge updates pending in the same edge that
  // copies the old pending value into active, so it takes effect one period
  // later.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_cnt     <= '0;
      r_per_act <= CNT_W'(DEF_PERIOD);
    end else if (!enable) begin
      r_cnt     <= '0;
      r_per_act <= r_per_pend;
    end else if (w_wrap) begin
      r_cnt     <= '0;
      r_per_act <= r_per_pend;
    end else begin
      r_cnt     <= r_cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign w_duty_we[i] = wr_en && (wr_addr == (ADDR_DUTY_BASE + 4'(i)));

    pwm_servo_chan #(
      .CNT_W(CNT_W)
`ifdef SERVO_RAMP_EN
      ,
      .RAMP_STEP(RAMP_STEP)
`endif
    ) u_chan (
      .clk     (clk),
      .res_n   (res_n),
      .i_enable(enable),
      .i_we    (w_duty_we[i]),
      .i_data  (wr_data),
      .i_load  (w_wrap),
      .i_cnt   (r_cnt),
      .o_pwm   (pwm[i])
    );
  end

endmodule

// File: tb/tb_pwm_servo_bank.sv
// -----------------------------------------------------------------------------
// tb_pwm_servo_bank
// Scoreboard bench for pwm_servo_bank (NCH=5, CNT_W=16, DEF_PERIOD=10,
// RAMP_STEP=2). Stimulus pushes the expected period length and per-channel
// duty for each complete period; the monitor rebuilds every period from the
// outputs (using per_end as the frame marker), then pops and compares the
// period length, each pulse width (min(duty, period)) and that each pulse is
// one contiguous run starting at count 0.
// -----------------------------------------------------------------------------
module tb_pwm_servo_bank;

  localparam int NCH   = 5;
  localparam int CNT_W = 16;

  logic             clk;
  logic             res_n;
  logic             enable;
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [CNT_W-1:0] wr_data;
  logic             per_end;
  logic [NCH-1:0]   pwm;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int per;
    int d[NCH];
  } exp_t;

  exp_t sb_q[$];

  pwm_servo_bank #(
    .NCH       (NCH),
    .CNT_W     (CNT_W),
    .DEF_PERIOD(10),
    .RAMP_STEP (2)
  ) dut (
    .clk    (clk),
    .res_n  (res_n),
    .enable (enable),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .per_end(per_end),
    .pwm    (pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb_q.size());
    $fatal(1, "watchdog");
  end

  function automatic void push(input int per, input int d0, input int d1,
                               input int d2, input int d3, input int d4);
    exp_t e;
    e.per  = per;
    e.d[0] = d0;
    e.d[1] = d1;
    e.d[2] = d2;
    e.d[3] = d3;
    e.d[4] = d4;
    sb_q.push_back(e);
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [CNT_W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  // Returns during a cycle in which per_end is high (last count of a period).
  task automatic sync_pe();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!per_end && n < 100);
    checks++;
    if (!per_end) begin
      errors++;
      $display("FAIL per_end_timeout: got no pulse in %0d cycles, required one", n);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    int  hi[NCH];
    bit  lo_seen[NCH];
    bit  bad[NCH];
    int  win_len;
    int  win_no;
    int  exp_w;
    bit  prev_live;
    bit  pe_prev;
    exp_t e;
    win_len   = 0;
    win_no    = 0;
    prev_live = 1'b0;
    pe_prev   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      hi[c] = 0; lo_seen[c] = 1'b0; bad[c] = 1'b0;
    end
    forever begin
      @(negedge clk);
      // pwm seen now reflects the counter of the previous cycle.
      if (!prev_live) begin
        win_len = 0;
        for (int c = 0; c < NCH; c++) begin
          hi[c] = 0; lo_seen[c] = 1'b0; bad[c] = 1'b0;
        end
      end else begin
        win_len++;
        for (int c = 0; c < NCH; c++) begin
          if (pwm[c]) begin
            hi[c]++;
            if (lo_seen[c]) bad[c] = 1'b1;
          end else begin
            lo_seen[c] = 1'b1;
          end
        end
        if (pe_prev) begin
          win_no++;
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: period %0d of length %0d, no expectation queued",
                     win_no, win_len);
          end else begin
            e = sb_q.pop_front();
            if (win_len != e.per) begin
              errors++;
              $display("FAIL period_len #%0d: got %0d expected %0d", win_no, win_len, e.per);
            end
            for (int c = 0; c < NCH; c++) begin
              exp_w = (e.d[c] < e.per) ? e.d[c] : e.per;
              checks++;
              if (hi[c] != exp_w || bad[c]) begin
                errors++;
                $display("FAIL width #%0d ch%0d: got %0d high (split=%0d) expected %0d contiguous",
                         win_no, c, hi[c], bad[c], exp_w);
              end
            end
          end
          win_len = 0;
          for (int c = 0; c < NCH; c++) begin
            hi[c] = 0; lo_seen[c] = 1'b0; bad[c] = 1'b0;
          end
        end
      end
      prev_live = res_n && enable;
      pe_prev   = per_end;
    end
  end

  // --------------------------------------------------------------- stimulus
  initial begin : stim
    res_n   = 1'b0;
    enable  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    tick();
    tick();
    chk("reset_pwm", int'(pwm), 0);
    chk("reset_per_end", int'(per_end), 0);
    res_n = 1'b1;

    // 1: duty0 = 3, default period 10
    repeat (3) push(10, 3, 0, 0, 0, 0);
    wr(4'd1, 16'd3);
    tick();
    enable = 1'b1;
    repeat (3) sync_pe();

    // 2: mid-period write, then a write on the period boundary
    push(10, 3, 0, 0, 0, 0);
`ifdef SERVO_RAMP_EN
    push(10, 5, 0, 0, 0, 0);
`else
    push(10, 6, 0, 0, 0, 0);
`endif
    push(10, 6, 0, 0, 0, 0);
    repeat (3) tick();
    wr(4'd1, 16'd6);
    sync_pe();
    sync_pe();
`ifdef SERVO_RAMP_EN
    push(10, 4, 0, 0, 0, 0);
`else
    push(10, 2, 0, 0, 0, 0);
`endif
    push(10, 2, 0, 0, 0, 0);
    wr(4'd1, 16'd2);
    repeat (3) sync_pe();

    // 3: duty 0 / = period / > period, then period 1 (acts as 2)
    push(10, 2, 0, 0, 0, 0);
`ifdef SERVO_RAMP_EN
    push(10, 2, 0, 2, 2, 0);
    push(10, 2, 0, 4, 4, 0);
`else
    push(10, 2, 0, 10, 15, 0);
    push(10, 2, 0, 10, 15, 0);
`endif
    wr(4'd3, 16'd10);
    wr(4'd4, 16'd15);
    wr(4'd2, 16'd0);
    repeat (3) sync_pe();
`ifdef SERVO_RAMP_EN
    push(10, 2, 0, 6, 6, 0);
`else
    push(10, 2, 0, 10, 15, 0);
`endif
    push(2, 2, 0, 10, 15, 0);
    push(2, 2, 0, 10, 15, 0);
    wr(4'd0, 16'd1);
    repeat (3) sync_pe();

    // 4: drop enable mid-pulse, reprogram while idle, restart
    push(2, 2, 0, 10, 15, 0);
    wr(4'd0, 16'd20);
    sync_pe();
    tick();
    tick();
    chk("pwm_mid_pulse", int'(pwm), 5'b01101);
    enable = 1'b0;
    tick();
    chk("pwm_after_disable", int'(pwm), 0);
    chk("per_end_after_disable", int'(per_end), 0);
    wr(4'd0, 16'd20);
    wr(4'd1, 16'd5);
    wr(4'd3, 16'd0);
    wr(4'd4, 16'd0);
    tick();
    repeat (2) push(20, 5, 0, 0, 0, 0);
    enable = 1'b1;
    repeat (2) sync_pe();

    // 5: out-of-range addresses change nothing
    repeat (2) push(20, 5, 0, 0, 0, 0);
    wr(4'd7, 16'd1);
    wr(4'd6, 16'd9);
    wr(4'd15, 16'd3);
    repeat (2) sync_pe();

    // 4b: asynchronous reset mid-pulse, then run on reset values
    tick();
    tick();
    chk("pwm_before_reset", int'(pwm), 5'b00001);
    res_n = 1'b0;
    #1;
    chk("pwm_async_reset", int'(pwm), 0);
    chk("per_end_async_reset", int'(per_end), 0);
    tick();
    tick();
    repeat (2) push(10, 0, 0, 0, 0, 0);
    res_n = 1'b1;
    repeat (2) sync_pe();

    // 6: duty0 0 -> 7 with period 20
    push(10, 0, 0, 0, 0, 0);
`ifdef SERVO_RAMP_EN
    push(20, 2, 0, 0, 0, 0);
    push(20, 4, 0, 0, 0, 0);
    push(20, 6, 0, 0, 0, 0);
    push(20, 7, 0, 0, 0, 0);
    push(20, 7, 0, 0, 0, 0);
`else
    repeat (5) push(20, 7, 0, 0, 0, 0);
`endif
    wr(4'd0, 16'd20);
    wr(4'd1, 16'd7);
    repeat (6) sync_pe();

    repeat (3) tick();
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
